// File: rtl/pipelined_adder.sv
// WIDTH-bit adder with carry-in, split into STAGES registered carry segments.
// Valid/ready on both sides; the whole pipeline stalls while the output is held.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int SW = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
    end

    logic w_en;

    assign w_en     = out_ready | ~out_valid;
    assign in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC_W = WIDTH - k * SW;
        localparam int SUM_W = (k + 1) * SW;
        localparam int REM_W = WIDTH - SUM_W;

        logic             w_vld_in;
        logic             w_c_in;
        logic [SRC_W-1:0] w_a_src;
        logic [SRC_W-1:0] w_b_src;
        logic [SW:0]      w_add;
        logic [SUM_W-1:0] w_sum_next;

        logic             r_valid;
        logic             r_carry;
        logic [SUM_W-1:0] r_sum;

        if (k == 0) begin : g_first
            assign w_vld_in   = in_valid;
            assign w_c_in     = cin;
            assign w_a_src    = A;
            assign w_b_src    = B;
            assign w_sum_next = w_add[SW-1:0];
        end else begin : g_next
            // Upper operand chunks travel skewed; finished low sum chunks travel de-skewed.
            assign w_vld_in   = g_stage[k-1].r_valid;
            assign w_c_in     = g_stage[k-1].r_carry;
            assign w_a_src    = g_stage[k-1].g_rem.r_a;
            assign w_b_src    = g_stage[k-1].g_rem.r_b;
            assign w_sum_next = {w_add[SW-1:0], g_stage[k-1].r_sum};
        end

        assign w_add = {1'b0, w_a_src[SW-1:0]} + {1'b0, w_b_src[SW-1:0]} + {{SW{1'b0}}, w_c_in};

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= '0;
            end else if (w_en) begin
                r_valid <= w_vld_in;
                if (w_vld_in) begin
                    r_carry <= w_add[SW];
                    r_sum   <= w_sum_next;
                end
            end
        end

        if (REM_W > 0) begin : g_rem
            logic [REM_W-1:0] r_a;
            logic [REM_W-1:0] r_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en && w_vld_in) begin
                    r_a <= w_a_src[SRC_W-1:SW];
                    r_b <= w_b_src[SRC_W-1:SW];
                end
            end
        end
    end

    assign sum       = g_stage[STAGES-1].r_sum;
    assign carry     = g_stage[STAGES-1].r_carry;
    assign out_valid = g_stage[STAGES-1].r_valid;

endmodule
